// File: rtl/shift_right_seq.sv
// Multi-cycle barrel right shifter (SRL/SRA), one power-of-two stage per clock.
module shift_right_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dataOut
);

    localparam int unsigned K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic                 fill_q, fill_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [WIDTH-1:0]     data_out_q, data_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     stage_res;
    logic [WIDTH-1:0]     stage_out;

    // Current stage: shift by 2^k; sign fill done by shifting the inverted word
    always_comb begin
        stage_res = '0;
        if (fill_q) begin
            stage_res = ~((~work_q) >> (WIDTH'(1) << k_q));
        end else begin
            stage_res = work_q >> (WIDTH'(1) << k_q);
        end
        stage_out = shamt_q[k_q] ? stage_res : work_q;
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        shamt_d    = shamt_q;
        fill_d     = fill_q;
        k_d        = k_q;
        data_out_d = data_out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_d  = data;
                    shamt_d = shamt;
                    fill_d  = arith & data[WIDTH-1];
                    k_d     = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = stage_out;
                k_d    = k_q + K_W'(1);
                if (k_q == K_W'(SHAMT_W - 1)) begin
                    data_out_d = stage_out;
                    state_d    = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            shamt_q    <= '0;
            fill_q     <= 1'b0;
            k_q        <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            shamt_q    <= shamt_d;
            fill_q     <= fill_d;
            k_q        <= k_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dataOut = data_out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases plus randomized traffic vs a timing/arithmetic model.
module tb_shift_right_seq;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int          LAT     = SHAMT_W + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   dataOut;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    shift_right_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data    (data),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input logic [SHAMT_W-1:0] s,
                                                   input logic a);
        logic signed [WIDTH-1:0] sd;
        logic [WIDTH-1:0]        r;
        sd = d;
        if (a) r = sd >>> s;
        else   r = d >> s;
        return r;
    endfunction

    // Model: m_phase = cycles since acceptance (0 = idle), result appears when it reaches LAT
    int               m_phase = 0;
    logic [WIDTH-1:0] m_pend  = '0;
    logic [WIDTH-1:0] m_out   = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_out   <= '0;
        end else if ((m_phase == 0 || m_phase == LAT) && start) begin
            m_phase <= 1;
            m_pend  <= ref_shift(data, shamt, arith);
        end else if (m_phase == LAT - 1) begin
            m_phase <= LAT;
            m_out   <= m_pend;
        end else if (m_phase == LAT) begin
            m_phase <= 0;
        end else if (m_phase != 0) begin
            m_phase <= m_phase + 1;
        end
    end

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", WIDTH'(busy), WIDTH'(m_phase >= 1 && m_phase < LAT));
            chk("done", WIDTH'(done), WIDTH'(m_phase == LAT));
            chk("dataOut", dataOut, m_out);
        end
    end

    task automatic run_one(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                           input logic a, input logic [WIDTH-1:0] exp);
        int cnt;
        int busy_cnt;
        @(negedge clk);
        data = d; shamt = s; arith = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data = $urandom; shamt = SHAMT_W'($urandom); arith = 1'($urandom);
        cnt = 0; busy_cnt = 0;
        while (!done && cnt < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cnt++;
        end
        chk("latency", WIDTH'(cnt), WIDTH'(LAT - 1));
        chk("busy_cycles", WIDTH'(busy_cnt), WIDTH'(SHAMT_W));
        chk("result", dataOut, exp);
        chk("model_pin", m_out, exp);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int gap_bad;

        reset = 1'b1; start = 1'b0; data = '0; shamt = '0; arith = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", WIDTH'(busy), '0);
        chk("rst_done", WIDTH'(done), '0);
        chk("rst_dataOut", dataOut, '0);
        reset = 1'b0;

        run_one(32'h1234_5678, 5'd4,  1'b0, 32'h0123_4567);
        run_one(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        run_one(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        run_one(32'hF000_0000, 5'd0,  1'b1, 32'hF000_0000);
        run_one(32'h7654_3210, 5'd8,  1'b1, 32'h0076_5432);
        run_one(32'hC000_0001, 5'd1,  1'b1, 32'hE000_0000);

        // start pulsed during SHIFT is ignored
        @(negedge clk);
        data = 32'hFFFF_0000; shamt = 5'd8; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        data = '0; shamt = '0; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        repeat (12) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("ignored_start_dones", WIDTH'(done_cnt), 32'd1);
        chk("ignored_start_result", dataOut, 32'h00FF_FF00);

        // start held continuously: done every LAT cycles
        start = 1'b1;
        done_cnt = 0; last_done = -1; gap_bad = 0;
        for (int c = 0; c < 8 * LAT; c++) begin
            data = $urandom; shamt = SHAMT_W'($urandom); arith = 1'($urandom);
            @(negedge clk);
            if (done) begin
                if (last_done >= 0 && (c - last_done) != LAT) gap_bad++;
                last_done = c;
                done_cnt++;
            end
        end
        start = 1'b0;
        chk("b2b_gap", WIDTH'(gap_bad), '0);
        chk("b2b_count", WIDTH'(done_cnt), 32'd8);
        repeat (LAT + 2) @(negedge clk);

        // reset in the 3rd SHIFT cycle aborts the request
        data = 32'hDEAD_BEEF; shamt = 5'd3; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", WIDTH'(busy), '0);
        chk("abort_done", WIDTH'(done), '0);
        chk("abort_dataOut", dataOut, '0);
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", WIDTH'(done_cnt), '0);

        // randomized traffic with occasional reset
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 2) == 0);
            data  = $urandom;
            shamt = SHAMT_W'($urandom);
            arith = 1'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        start = 1'b0; reset = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
